// File: rtl/div_gen.sv
// Programmable clock divider: registered clk_tx of N cycles (floor(N/2) high)
// plus a tick in the last low cycle; divisor changes land on period boundaries.
module div_gen #(
    parameter int W       = 8,
    parameter int DIV_RST = 8
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div_set,
    input  logic         div_load,
    output logic         div_busy,
    output logic         clk_tx,
    output logic         tick
);

    localparam logic [W-1:0] N_RST = W'(DIV_RST);
    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] TWO   = W'(2);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] act, act_n;
    logic [W-1:0] pend, pend_n;
    logic [W-1:0] n_use;
    logic         busy_n, clk_n, tick_n;
    logic         boundary, apply;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        act_n    = act;
        pend_n   = pend;
        busy_n   = div_busy;
        clk_n    = 1'b0;
        tick_n   = 1'b0;
        apply    = 1'b0;
        n_use    = act;
        // A fresh start from idle counts as a period boundary
        boundary = (state == S_IDLE) || (cnt == act - ONE);

        if (en) begin
            apply   = div_busy && boundary;
            n_use   = apply ? pend : act;
            state_n = S_RUN;
            cnt_n   = boundary ? '0 : cnt + ONE;
            clk_n   = cnt_n < (n_use >> 1);
            tick_n  = cnt_n == n_use - ONE;
        end else begin
            apply   = div_busy;
            state_n = S_IDLE;
            cnt_n   = '0;
        end

        if (apply) begin
            act_n  = pend;
            busy_n = 1'b0;
        end

        // Capture only when nothing is pending (sampled before this edge)
        if (div_load && !div_busy) begin
            pend_n = (div_set < TWO) ? TWO : div_set;
            busy_n = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            act      <= N_RST;
            pend     <= '0;
            div_busy <= 1'b0;
            clk_tx   <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            act      <= act_n;
            pend     <= pend_n;
            div_busy <= busy_n;
            clk_tx   <= clk_n;
            tick     <= tick_n;
        end
    end

endmodule

// File: doc/div_gen.md
DIV_GEN -- requirements
Module: div_gen

Interface
REQ-001 Parameter W, default 8, width of divisor and internal counter; legal range 2..16.
REQ-002 Parameter DIV_RST, default 8, divisor active after reset; legal range 2..2^W-1.
REQ-003 clk_sys  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  run enable; 0 = divider idle.
REQ-006 div_set  input  W  requested divisor N.
REQ-007 div_load  input  1  one-cycle request to capture div_set.
REQ-008 div_busy  output  1  a captured divisor is pending and not yet applied.
REQ-009 clk_tx  output  1  divided clock, registered, glitch-free.
REQ-010 tick  output  1  one-cycle strobe, one per divided period.

Function
REQ-011 Active divisor N (div_act) SHALL set the period of clk_tx to exactly N clk_sys cycles.
REQ-012 clk_tx SHALL be high for H = floor(N/2) cycles, then low for N-H cycles, each period.
REQ-013 tick SHALL be 1 only in the last low cycle of each period.
REQ-014 Examples: N=2 -> 1 high/1 low; N=3 -> 1 high/2 low; N=8 -> 4 high/4 low.
REQ-015 Internal counter SHALL run 0..N-1 and wrap to 0; counter wrap SHALL use no width beyond W.
REQ-016 en sampled 1 at edge k (with prior en=0) -> clk_tx first high in cycle k+1; one-cycle start latency.
REQ-017 en sampled 0 -> next cycle clk_tx=0, tick=0, counter=0; the partial period is abandoned.
REQ-018 en re-asserted -> a full new period starts per REQ-016; no partial period.
REQ-019 div_load=1 with div_busy=0 -> div_set captured into pending register, div_busy=1 next cycle.
REQ-020 div_load=1 with div_busy=1 -> ignored; pending value unchanged.
REQ-021 Captured values 0 or 1 SHALL be clamped to 2.
REQ-022 With en=1, pending divisor SHALL become active at the period boundary (cycle after tick).
REQ-023 The new period SHALL start with counter 0 and the new N; div_busy SHALL clear in that same cycle.
REQ-024 With en=0, pending divisor SHALL become active on the next edge; div_busy SHALL be high for exactly one cycle.
REQ-025 div_load in the same cycle as tick -> value pending; the period just starting uses the old N; switch at the following boundary.
REQ-026 Divisor changes SHALL never produce a clk_tx high or low phase shorter than min(H_old, H_new), nor a runt pulse.
REQ-027 Active divisor SHALL be unchanged while en=1 except at a period boundary.

Reset
REQ-028 rst_n sampled 0 -> next cycle: div_act=DIV_RST, counter=0, pending cleared, div_busy=0, clk_tx=0, tick=0.
REQ-029 Reset SHALL override en and div_load in the same cycle.
REQ-030 Reset asserted mid-period or with a divisor pending SHALL discard the pending value.
REQ-031 After rst_n returns high, behaviour SHALL follow REQ-016 with N=DIV_RST.

Verification
REQ-032 Reset, en=1, W=8, DIV_RST=8 -> clk_tx 4 high/4 low repeating; tick every 8th cycle; first high 1 cycle after en.
REQ-033 div_set=3, div_load pulse mid-period -> div_busy high until boundary; old period completes, then 1 high/2 low; tick every 3 cycles.
REQ-034 div_set=0 loaded -> clamped: 1 high/1 low; second div_load while busy -> ignored; div_busy clears at boundary.
REQ-035 en dropped at counter=5 with N=8 -> clk_tx=0 next cycle; re-assert -> full 4/4 period, no runt.
REQ-036 div_load coincident with tick (N=8 -> 5) -> one more 8-cycle period, then 2 high/3 low.
REQ-037 rst_n=0 mid-period with divisor pending -> all outputs 0, div_busy 0; restart at N=8.
